// File: rtl/mole_pkg.sv
// mole_pkg: shared constants for the whack-a-mole round sequencer.
//   State encoding : ST_IDLE, ST_SPAWN, ST_SHOW, ST_CLEAR, ST_GAP, ST_DONE
//   Hole codes     : POS_NONE (no mole), POS_CLEAR (judge re-arm), POS_MAX (last hole)
//   pick_hole()    : maps an LFSR value to a hole 1..9 that differs from the previous one
package mole_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SPAWN = 3'd1;
   localparam logic [2:0] ST_SHOW  = 3'd2;
   localparam logic [2:0] ST_CLEAR = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   localparam logic [3:0] POS_NONE  = 4'd0;
   localparam logic [3:0] POS_CLEAR = 4'd11;
   localparam logic [3:0] POS_MAX   = 4'd9;

   // A repeat of the previous hole is bumped to the next hole (9 wraps to 1)
   // so the player always sees the mole move.
   function automatic logic [3:0] pick_hole(input logic [7:0] lfsr, input logic [3:0] prev);
      logic [7:0] rem;
      logic [3:0] cand;
      rem  = lfsr % 8'd9;
      cand = rem[3:0] + 4'd1;
      if (cand == prev) begin
         cand = (cand == POS_MAX) ? 4'd1 : cand + 4'd1;
      end
      return cand;
   endfunction

endpackage

// File: rtl/mole_lfsr.sv
// mole_lfsr: 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
//   clk   in  system clock
//   rst   in  asynchronous active-high reset, loads SEED
//   en    in  step enable
//   state out current 8-bit LFSR value
// SEED must be non-zero or the register locks up at zero.
module mole_lfsr #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic [7:0] state
);

   logic feedback;
   assign feedback = state[7] ^ state[5] ^ state[4] ^ state[3];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SEED;
      end else if (en) begin
         state <= {state[6:0], feedback};
      end
   end

endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler: round sequencer for the whack-a-mole game.
//   Picks a pseudo-random hole, shows it to the hit judge for a hold window,
//   scores the round from the judge's sticky hit, then emits the clear code so
//   the judge re-arms.
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   start      in   1-cycle pulse, honoured only in IDLE or DONE
//   hit        in   sticky hit from the judge
//   pos_0      out  0 = no mole, 1..9 = active hole, 11 = clear code
//   ready      out  high while a mole is hittable
//   score      out  hits this game (saturating)
//   miss_cnt   out  timeouts this game
//   round_cnt  out  completed rounds
//   game_over  out  high once the game has ended
// Build option: define MOLE_DIFFICULTY_RAMP_EN to shrink the hold window by
//   HOLD_STEP on every hit, floored at HOLD_MIN; otherwise hold is constant.
module mole_scheduler
   import mole_pkg::*;
#(
   parameter int         HOLD_CYCLES = 50_000_000,
   parameter int         GAP_CYCLES  = 10_000_000,
   parameter int         ROUNDS      = 30,
   parameter int         MAX_MISS    = 5,
   parameter logic [7:0] LFSR_SEED   = 8'hA5,
   parameter int         HOLD_STEP   = 2_000_000,
   parameter int         HOLD_MIN    = 15_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       hit,
   output logic [3:0] pos_0,
   output logic       ready,
   output logic [7:0] score,
   output logic [3:0] miss_cnt,
   output logic [7:0] round_cnt,
   output logic       game_over
);

   localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   logic [2:0]    state;
   logic [TW-1:0] timer;
   logic [TW-1:0] hold_reg;
   logic [TW-1:0] hold_after_hit;
   logic [3:0]    hole_reg;
   logic [3:0]    next_hole;
   logic [7:0]    lfsr;

   mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .en    (1'b1),
      .state (lfsr)
   );

   assign next_hole = pick_hole(lfsr, hole_reg);

`ifdef MOLE_DIFFICULTY_RAMP_EN
   // Compare at 32 bits so HOLD_MIN+HOLD_STEP cannot overflow the timer width.
   logic [31:0] hold_wide;
   assign hold_wide = 32'(hold_reg);
   always_comb begin
      hold_after_hit = TW'(HOLD_MIN);
      if (hold_wide >= 32'(HOLD_MIN + HOLD_STEP)) begin
         hold_after_hit = hold_reg - TW'(HOLD_STEP);
      end
   end
`else
   assign hold_after_hit = hold_reg;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         pos_0     <= POS_NONE;
         ready     <= 1'b0;
         score     <= 8'd0;
         miss_cnt  <= 4'd0;
         round_cnt <= 8'd0;
         game_over <= 1'b0;
         hold_reg  <= TW'(HOLD_CYCLES);
         timer     <= '0;
         hole_reg  <= POS_NONE;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               pos_0 <= POS_NONE;
               ready <= 1'b0;
               if (start) begin
                  score     <= 8'd0;
                  miss_cnt  <= 4'd0;
                  round_cnt <= 8'd0;
                  hold_reg  <= TW'(HOLD_CYCLES);
                  game_over <= 1'b0;
                  state     <= ST_SPAWN;
               end
            end
            ST_SPAWN: begin
               hole_reg <= next_hole;
               pos_0    <= next_hole;
               ready    <= 1'b1;
               timer    <= hold_reg - TW'(1);
               state    <= ST_SHOW;
            end
            ST_SHOW: begin
               // hit is tested first so a hit on the final cycle scores.
               if (hit) begin
                  if (score != 8'hFF) begin
                     score <= score + 8'd1;
                  end
                  hold_reg <= hold_after_hit;
                  pos_0    <= POS_CLEAR;
                  ready    <= 1'b0;
                  state    <= ST_CLEAR;
               end else if (timer == '0) begin
                  miss_cnt <= miss_cnt + 4'd1;
                  pos_0    <= POS_CLEAR;
                  ready    <= 1'b0;
                  state    <= ST_CLEAR;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            ST_CLEAR: begin
               round_cnt <= round_cnt + 8'd1;
               pos_0     <= POS_NONE;
               if ((miss_cnt == 4'(MAX_MISS)) || ((round_cnt + 8'd1) == 8'(ROUNDS))) begin
                  game_over <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  timer <= TW'(GAP_CYCLES - 1);
                  state <= ST_GAP;
               end
            end
            ST_GAP: begin
               pos_0 <= POS_NONE;
               if (timer == '0) begin
                  state <= ST_SPAWN;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            default: begin
               pos_0 <= POS_NONE;
               ready <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
